ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port design RAM between the UART boot loader (port A) and the core/scan-side requester (port B). It sequences every RAM access as a fixed four-state transaction, returns captured read data, and gives port A exclusive ownership while boot is in progress. It sits between both requesters and the RAM enable/rw/address/data pins.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- ce  input  1  clock enable; FSM and all registers hold when 0
- boot_hold  input  1  1 = port A exclusive, port B never granted
- a_req / b_req  input  1  access request, held high until matching ack
- a_rw / b_rw  input  1  1 = write, 0 = read; stable while req high
- a_adr / b_adr  input  ADDR_W  access address
- a_wdata / b_wdata  input  DATA_W  write data
- a_ack / b_ack  output  1  one-cycle completion pulse
- a_rdata / b_rdata  output  DATA_W  read data, valid from ack cycle until the port's next read completes
- ram_enable  output  1  RAM strobe, high exactly one cycle per access
- ram_rw  output  1  1 = write, 0 = read
- ram_adr  output  ADDR_W  RAM address
- ram_in  output  DATA_W  data to RAM
- ram_out  input  DATA_W  data from RAM, valid the cycle after ram_enable (synchronous read)
- busy  output  1  high in every state except IDLE
- grant_b  output  1  owner of the current/last transaction: 0 = A, 1 = B

## Operation
- All outputs are registered. Reset value of every output is 0; last_owner register resets to B (so A wins the first tie).
- States: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. Advance only on edges with ce=1.
- IDLE: eligible = {a_req, b_req & ~boot_hold}. None: stay. One: grant it. Both: grant the port that is not last_owner (round robin). On grant: latch rw/adr/wdata into ram_rw/ram_adr/ram_in, set ram_enable=1, grant_b, last_owner, go ACCESS.
- ACCESS: ram_enable=1 for this cycle only; next edge clears ram_enable, go WAIT. ram_adr/ram_in/ram_rw stay stable until the next grant.
- WAIT: for reads, capture ram_out into the owner's rdata on the exiting edge; writes leave rdata unchanged. Set owner's ack=1, go DONE.
- DONE: ack high this cycle; next edge clears ack, go IDLE. Requester drops req during DONE; req still high in IDLE is a new request.
- boot_hold rising while B owns a transaction: B's transaction completes normally; only new B grants are blocked.
- req dropped before ack: transaction still completes, ack still pulses (protocol violation, not flagged).
- rw/adr/wdata changes after grant are ignored.
- rst_n low at any time: immediate abort, all outputs 0, no ack issued, state IDLE.

## Timing
- Grant edge E0 (IDLE, req seen) -> ram_enable high cycle E0..E1 -> ram_out sampled at E2 -> ack high cycle E2..E3 -> IDLE at E3.
- Latency req-sampled to ack = 2 cycles after grant edge; access period 4 cycles; max throughput one access per 4 ce cycles.
- Back-to-back: a request present in IDLE after E3 is granted at E3+1 edge; no idle bubble beyond the IDLE cycle.
- ce=0 stretches any state, including ram_enable and ack, by the number of stalled cycles.

## Test plan
- Reset: assert rst_n=0 mid-ACCESS -> all outputs 0 immediately, no ack; after release busy=0, ram_enable=0.
- A write 0x5A to 0x10 then A read 0x10 -> ram_enable one cycle each with ram_rw=1 then 0, a_ack 2 edges after grant, a_rdata=0x5A, b_ack never pulses.
- a_req and b_req held high together for 4 transactions, boot_hold=0 -> grant order A,B,A,B; grant_b=0,1,0,1; each access 4 cycles.
- boot_hold=1, b_req high for 20 cycles, A idle -> no B grant, ram_enable stays 0; drop boot_hold -> B granted next IDLE edge.
- ce toggled 1/0 each cycle during B read of 0x33 (RAM holds 0xC3) -> ram_enable high 2 cycles, ack high 2 cycles, b_rdata=0xC3.
- B read in progress, raise boot_hold -> B transaction completes with b_ack; pending a_req granted next.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM: port A (boot loader) and port B (core/scan).
// Every access is a fixed IDLE -> ACCESS -> WAIT -> DONE sequence; boot_hold locks out new B grants.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              boot_hold,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_adr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_adr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              grant_b
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              ram_enable_q, ram_enable_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;
    logic              grant_b_q, grant_b_d;
    logic              last_owner_q, last_owner_d;
    logic              busy_q, busy_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic a_elig, b_elig, pick_b;

    assign a_elig = a_req;
    assign b_elig = b_req & ~boot_hold;
    // On a tie, the port that did not own the last transaction wins.
    assign pick_b = b_elig & (~a_elig | ~last_owner_q);

    always_comb begin
        state_d      = state_q;
        ram_enable_d = ram_enable_q;
        ram_rw_d     = ram_rw_q;
        ram_adr_d    = ram_adr_q;
        ram_in_d     = ram_in_q;
        grant_b_d    = grant_b_q;
        last_owner_d = last_owner_q;
        busy_d       = busy_q;
        a_ack_d      = a_ack_q;
        b_ack_d      = b_ack_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (a_elig || b_elig) begin
                        ram_rw_d     = pick_b ? b_rw : a_rw;
                        ram_adr_d    = pick_b ? b_adr : a_adr;
                        ram_in_d     = pick_b ? b_wdata : a_wdata;
                        ram_enable_d = 1'b1;
                        grant_b_d    = pick_b;
                        last_owner_d = pick_b;
                        busy_d       = 1'b1;
                        state_d      = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    ram_enable_d = 1'b0;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    // RAM read data is valid the cycle after the strobe.
                    if (!ram_rw_q) begin
                        if (grant_b_q) b_rdata_d = ram_out;
                        else           a_rdata_d = ram_out;
                    end
                    if (grant_b_q) b_ack_d = 1'b1;
                    else           a_ack_d = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    a_ack_d = 1'b0;
                    b_ack_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ram_enable_q <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_adr_q    <= '0;
            ram_in_q     <= '0;
            grant_b_q    <= 1'b0;
            last_owner_q <= 1'b1;
            busy_q       <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            ram_enable_q <= ram_enable_d;
            ram_rw_q     <= ram_rw_d;
            ram_adr_q    <= ram_adr_d;
            ram_in_q     <= ram_in_d;
            grant_b_q    <= grant_b_d;
            last_owner_q <= last_owner_d;
            busy_q       <= busy_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign ram_enable = ram_enable_q;
    assign ram_rw     = ram_rw_q;
    assign ram_adr    = ram_adr_q;
    assign ram_in     = ram_in_q;
    assign grant_b    = grant_b_q;
    assign busy       = busy_q;
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous-read RAM on the RAM pins.
module tb_ram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n, ce, boot_hold;
    logic              a_req, a_rw, b_req, b_rw;
    logic [ADDR_W-1:0] a_adr, b_adr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_ack, b_ack, ram_enable, ram_rw, busy, grant_b;
    logic [DATA_W-1:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [ADDR_W-1:0] ram_adr;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    int vec_cnt = 0;
    int err_cnt = 0;
    int b_ack_seen = 0;
    int en_cnt, ack_cnt;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .boot_hold(boot_hold),
        .a_req(a_req), .a_rw(a_rw), .a_adr(a_adr), .a_wdata(a_wdata),
        .b_req(b_req), .b_rw(b_rw), .b_adr(b_adr), .b_wdata(b_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_adr(ram_adr),
        .ram_in(ram_in), .ram_out(ram_out), .busy(busy), .grant_b(grant_b)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else        ram_out <= mem[ram_adr];
        end
    end

    always @(posedge clk) if (b_ack) b_ack_seen <= b_ack_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        ram_out = '0;
        ce = 1'b1; boot_hold = 1'b0;
        a_req = 1'b0; a_rw = 1'b0; a_adr = '0; a_wdata = '0;
        b_req = 1'b0; b_rw = 1'b0; b_adr = '0; b_wdata = '0;
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_en", ram_enable, 0);
        check("rst_grant", grant_b, 0);
        check("rst_aack", a_ack, 0);

        // A write 0x5A to 0x10
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h10; a_wdata = 8'h5A;
        tick();
        check("wr_en", ram_enable, 1);
        check("wr_rw", ram_rw, 1);
        check("wr_adr", ram_adr, 8'h10);
        check("wr_din", ram_in, 8'h5A);
        check("wr_grant", grant_b, 0);
        check("wr_busy", busy, 1);
        a_wdata = 8'hFF;
        tick();
        check("wr_en_off", ram_enable, 0);
        check("wr_ack_early", a_ack, 0);
        tick();
        check("wr_ack", a_ack, 1);
        a_req = 1'b0;
        tick();
        check("wr_ack_off", a_ack, 0);
        check("wr_idle", busy, 0);

        // A read of 0x10
        a_req = 1'b1; a_rw = 1'b0; a_adr = 8'h10;
        tick();
        check("rd_en", ram_enable, 1);
        check("rd_rw", ram_rw, 0);
        tick();
        check("rd_en_off", ram_enable, 0);
        tick();
        check("rd_ack", a_ack, 1);
        check("rd_data", a_rdata, 8'h5A);
        a_req = 1'b0;
        tick();
        check("rd_ack_off", a_ack, 0);
        check("no_b_ack", b_ack_seen, 0);

        // Round robin with both requesting, starting from reset
        do_reset();
        a_req = 1'b1; a_rw = 1'b0; a_adr = 8'h10;
        b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h10;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("rr%0d_grant", t), grant_b, t % 2);
            check($sformatf("rr%0d_en", t), ram_enable, 1);
            tick();
            tick();
            check($sformatf("rr%0d_aack", t), a_ack, (t % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_back", t), b_ack, (t % 2 == 1) ? 1 : 0);
            if (t == 3) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            tick();
            check($sformatf("rr%0d_idle", t), busy, 0);
        end

        // boot_hold blocks B entirely
        boot_hold = 1'b1; b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h10;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("hold%0d_en", i), {busy, ram_enable}, 0);
        end
        boot_hold = 1'b0;
        tick();
        check("unhold_grant", grant_b, 1);
        check("unhold_en", ram_enable, 1);
        tick();
        tick();
        check("unhold_ack", b_ack, 1);
        b_req = 1'b0;
        tick();

        // ce toggling during a B read of 0x33
        mem[8'h33] = 8'hC3;
        b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h33;
        en_cnt = 0; ack_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ce = (i % 2 == 0);
            tick();
            if (ram_enable) en_cnt++;
            if (b_ack) begin
                ack_cnt++;
                b_req = 1'b0;
            end
        end
        ce = 1'b1;
        check("ce_en_cycles", en_cnt, 2);
        check("ce_ack_cycles", ack_cnt, 2);
        check("ce_rdata", b_rdata, 8'hC3);

        // boot_hold raised during a B read; pending A follows
        b_req = 1'b1; b_rw = 1'b0; b_adr = 8'h33;
        tick();
        check("bh_grant_b", grant_b, 1);
        boot_hold = 1'b1;
        a_req = 1'b1; a_rw = 1'b0; a_adr = 8'h10;
        tick();
        tick();
        check("bh_back", b_ack, 1);
        check("bh_brdata", b_rdata, 8'hC3);
        check("bh_aack_no", a_ack, 0);
        b_req = 1'b0;
        tick();
        tick();
        check("bh_grant_a", grant_b, 0);
        check("bh_adr_a", ram_adr, 8'h10);
        tick();
        tick();
        check("bh_aack", a_ack, 1);
        check("bh_ardata", a_rdata, 8'h5A);
        a_req = 1'b0;
        boot_hold = 1'b0;
        tick();

        // Reset asserted mid-ACCESS
        a_req = 1'b1; a_rw = 1'b1; a_adr = 8'h44; a_wdata = 8'h99;
        tick();
        check("mid_en_pre", ram_enable, 1);
        rst_n = 1'b0;
        #1;
        check("mid_en", ram_enable, 0);
        check("mid_busy", busy, 0);
        check("mid_adr", ram_adr, 0);
        check("mid_rw", ram_rw, 0);
        check("mid_ardata", a_rdata, 0);
        a_req = 1'b0;
        tick();
        tick();
        check("mid_aack", a_ack, 0);
        rst_n = 1'b1;
        tick();
        check("post_busy", busy, 0);
        check("post_en", ram_enable, 0);
        check("post_aack", a_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
